// File: rtl/fpu_op_dispatch.sv
// fpu_op_dispatch
//   Sequencing controller between the host decode logic and the operand demux /
//   floating-point unit array. Accepts one request at a time, holds the unit
//   select and operands stable, pulses a start to the chosen unit, waits for its
//   done strobe (bounded by a timeout), then captures and presents the result.
//
// Ports
//   clk, n_rst        : rising-edge clock, asynchronous active-low reset
//   start, opcode     : request strobe (sampled only in IDLE) and target unit index
//   op1, op2          : request operands
//   unit_done         : per-unit completion strobes (only the selected bit counts, only in WAIT)
//   unit_result       : per-unit results, packed, unit i at [32*i+31:32*i]
//   select            : registered demux select
//   op1_q, op2_q      : registered operands driven to the demux
//   unit_start        : one-hot start pulse to the selected unit (ISSUE state)
//   result            : captured result, held until the next capture
//   result_valid      : one-cycle pulse when result is new (DONE state)
//   busy              : high whenever the controller is not IDLE
//   error             : one-cycle registered pulse on illegal opcode or timeout
module fpu_op_dispatch #(
   parameter int NUM_UNITS = 6,
   parameter int TIMEOUT   = 64
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start,
   input  logic [2:0]              opcode,
   input  logic [31:0]             op1,
   input  logic [31:0]             op2,
   input  logic [NUM_UNITS-1:0]    unit_done,
   input  logic [NUM_UNITS*32-1:0] unit_result,
   output logic [2:0]              select,
   output logic [31:0]             op1_q,
   output logic [31:0]             op2_q,
   output logic [NUM_UNITS-1:0]    unit_start,
   output logic [31:0]             result,
   output logic                    result_valid,
   output logic                    busy,
   output logic                    error
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       select_q, select_d;
   logic [31:0]      op1_d, op2_d;
   logic [31:0]      result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             error_q, error_d;

   logic             opcode_legal;
   logic             done_sel;
   logic [31:0]      result_sel;
   logic             issue;

   // Zero-extend before comparing so NUM_UNITS = 8 makes every opcode legal.
   assign opcode_legal = ({29'd0, opcode} < 32'(NUM_UNITS));

   // Pick out the selected unit's done and result; other units are invisible.
   always_comb begin
      done_sel   = 1'b0;
      result_sel = 32'd0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (select_q == 3'(i)) begin
            done_sel   = unit_done[i];
            result_sel = unit_result[32*i +: 32];
         end
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && opcode_legal) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            // done takes priority over the timeout on the final count
            if (done_sel) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_IDLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      select_d = select_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      error_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (opcode_legal) begin
                  select_d = opcode;
                  op1_d    = op1;
                  op2_d    = op2;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_ISSUE: cnt_d = '0;
         S_WAIT: begin
            if (done_sel) begin
               result_d = result_sel;
            end else if (cnt_q == CNT_MAX) begin
               error_d = 1'b1;
            end else begin
               // only incremented below CNT_MAX, so it saturates rather than wraps
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         select_q <= 3'd0;
         op1_q    <= 32'd0;
         op2_q    <= 32'd0;
         result_q <= 32'd0;
         cnt_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         select_q <= select_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         error_q  <= error_d;
      end
   end

   // ---------------- outputs decoded from registered state ----------------
   always_comb begin
      busy         = (state_q != S_IDLE);
      result_valid = (state_q == S_DONE);
      issue        = (state_q == S_ISSUE);
   end

   generate
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_start
         assign unit_start[gi] = issue && (select_q == 3'(gi));
      end
   endgenerate

   assign select = select_q;
   assign result = result_q;
   assign error  = error_q;

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Self-checking bench for fpu_op_dispatch. A transaction-level model turns each
// request (opcode, done timing, extra strobes) into a schedule of cycle numbers
// relative to the start cycle; a negedge process compares every output each cycle.
module tb_fpu_op_dispatch;
   localparam int NU = 6;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            n_rst = 1'b1;
   logic            start = 1'b0;
   logic [2:0]      opcode = 3'd0;
   logic [31:0]     op1 = 32'd0;
   logic [31:0]     op2 = 32'd0;
   logic [NU-1:0]   unit_done = '0;
   logic [NU*32-1:0] unit_result;
   logic [2:0]      select;
   logic [31:0]     op1_q, op2_q, result;
   logic [NU-1:0]   unit_start;
   logic            result_valid, busy, error;

   fpu_op_dispatch #(.NUM_UNITS(NU), .TIMEOUT(TO)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .opcode(opcode), .op1(op1), .op2(op2),
      .unit_done(unit_done), .unit_result(unit_result), .select(select),
      .op1_q(op1_q), .op2_q(op2_q), .unit_start(unit_start), .result(result),
      .result_valid(result_valid), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- model: schedule of absolute cycle numbers ----------------
   int          m_lo = 0, m_hi = -1, m_issue = -1, m_valid = -1, m_err = -1;
   logic [2:0]  m_sel_old = 3'd0, m_sel_new = 3'd0;
   logic [31:0] m_a_old = 0, m_a_new = 0, m_b_old = 0, m_b_new = 0;
   logic [31:0] m_res_old = 0, m_res_new = 0;

   task automatic model_reset();
      m_lo = 0; m_hi = -1; m_issue = -1; m_valid = -1; m_err = -1;
      m_sel_old = 0; m_sel_new = 0; m_a_old = 0; m_a_new = 0;
      m_b_old = 0; m_b_new = 0; m_res_old = 0; m_res_new = 0;
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic        latched, captured;
      logic [NU-1:0] exp_us;
      latched  = (m_issue >= 0) && (cyc >= m_issue);
      captured = (m_valid >= 0) && (cyc >= m_valid);
      exp_us   = '0;
      if (cyc == m_issue) exp_us[m_sel_new] = 1'b1;
      chk("busy",         32'(busy),         32'((cyc >= m_lo) && (cyc <= m_hi)));
      chk("unit_start",   32'(unit_start),   32'(exp_us));
      chk("result_valid", 32'(result_valid), 32'(cyc == m_valid));
      chk("error",        32'(error),        32'(cyc == m_err));
      chk("select",       32'(select),       32'(latched ? m_sel_new : m_sel_old));
      chk("op1_q",        op1_q,             latched ? m_a_new : m_a_old);
      chk("op2_q",        op2_q,             latched ? m_b_new : m_b_old);
      chk("result",       result,            captured ? m_res_new : m_res_old);
   end

   // probes: snapshot outputs at two chosen relative cycles for literal checks
   logic        p_busy[2], p_err[2], p_val[2];
   logic [NU-1:0] p_us[2];
   logic [2:0]  p_sel[2];
   logic [31:0] p_res[2];

   // Runs one request. Called at posedge+1; the current cycle is relative cycle 0.
   // d_rel: selected unit's done cycle (0 = never); n_unit/n_rel: another done strobe;
   // s_rel: an extra start while busy; abort_rel: cycle in which n_rst pulses low.
   task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int d_rel, input int n_unit,
                         input int n_rel, input int s_rel, input int abort_rel,
                         input int pa_rel, input int pb_rel);
      int s0, d, last_rel;
      s0 = cyc;
      m_sel_old = m_sel_new; m_a_old = m_a_new; m_b_old = m_b_new; m_res_old = m_res_new;
      d = 0;
      if (op < NU) begin
         if (d_rel >= 2 && d_rel <= TO + 1) d = d_rel;
         if (n_unit == op && n_rel >= 2 && n_rel <= TO + 1 && (d == 0 || n_rel < d)) d = n_rel;
         unit_result[32*op +: 32] = res;
         m_sel_new = 3'(op); m_a_new = a; m_b_new = b;
         m_issue = s0 + 1; m_lo = s0 + 1;
         if (d != 0) begin
            m_valid = s0 + d + 1; m_hi = s0 + d + 1; m_err = -1; m_res_new = res;
         end else begin
            m_valid = -1; m_hi = s0 + TO + 1; m_err = s0 + TO + 2;
         end
         last_rel = m_hi - s0 + 1;
      end else begin
         m_issue = -1; m_lo = s0 + 1; m_hi = s0; m_valid = -1; m_err = s0 + 1;
         last_rel = 1;
      end
      if (abort_rel > 0) last_rel = abort_rel;
      for (int r = 0; r <= last_rel; r++) begin
         start     = (r == 0) || (s_rel > 0 && r == s_rel);
         opcode    = (r == 0) ? 3'(op) : 3'd0;
         op1       = (r == 0) ? a : ~a;
         op2       = (r == 0) ? b : ~b;
         unit_done = '0;
         if (d_rel > 0 && r == d_rel && op < NU) unit_done[op] = 1'b1;
         if (n_rel > 0 && r == n_rel) unit_done[n_unit] = 1'b1;
         if (abort_rel > 0 && r == abort_rel) begin
            #2 n_rst = 1'b0;
            model_reset();
         end
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (r == ((k == 0) ? pa_rel : pb_rel)) begin
               p_busy[k] = busy; p_err[k] = error; p_val[k] = result_valid;
               p_us[k] = unit_start; p_sel[k] = select; p_res[k] = result;
            end
         end
         @(posedge clk); #1;
         if (abort_rel > 0 && r == abort_rel) begin
            n_rst = 1'b1;
            break;
         end
      end
      start = 1'b0;
      unit_done = '0;
   endtask

   initial begin
      for (int i = 0; i < NU; i++) unit_result[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
      #1 n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;

      // basic: unit 2 done one cycle after its start
      run_op(2, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2, 0, 0, 0, 0, 1, 3);
      chk("t1_unit_start_c1", 32'(p_us[0]), 32'h0000_0004);
      chk("t1_busy_c1",       32'(p_busy[0]), 32'd1);
      chk("t1_valid_c3",      32'(p_val[1]), 32'd1);
      chk("t1_result_c3",     p_res[1], 32'h4040_0000);

      // illegal opcodes 7 and 6 (= NUM_UNITS)
      run_op(7, 32'h1111_1111, 32'h2222_2222, 32'h0, 0, 0, 0, 0, 0, 1, 2);
      chk("t2_error_c1",  32'(p_err[0]), 32'd1);
      chk("t2_busy_c1",   32'(p_busy[0]), 32'd0);
      chk("t2_select_c1", 32'(p_sel[0]), 32'd2);
      chk("t2_error_c2",  32'(p_err[1]), 32'd0);
      run_op(6, 32'h1, 32'h2, 32'h0, 0, 0, 0, 0, 0, 1, 1);
      chk("t2b_error_c1", 32'(p_err[0]), 32'd1);

      // timeout on unit 1
      run_op(1, 32'hC000_0000, 32'h0000_0001, 32'h0, 0, 0, 0, 0, 0, 66, 65);
      chk("t3_error_c66",  32'(p_err[0]), 32'd1);
      chk("t3_busy_c66",   32'(p_busy[0]), 32'd0);
      chk("t3_result_c66", p_res[0], 32'h4040_0000);
      chk("t3_busy_c65",   32'(p_busy[1]), 32'd1);
      chk("t3_error_c65",  32'(p_err[1]), 32'd0);

      // unit 3 done is ignored, extra start during busy is ignored
      run_op(4, 32'hAAAA_0001, 32'hBBBB_0002, 32'h1234_5678, 12, 3, 7, 3, 0, 13, 4);
      chk("t4_valid_c13",  32'(p_val[0]), 32'd1);
      chk("t4_result_c13", p_res[0], 32'h1234_5678);
      chk("t4_select_c4",  32'(p_sel[1]), 32'd4);

      // done on the last count wins over the timeout
      run_op(5, 32'h5, 32'h6, 32'h0BAD_F00D, TO + 1, 0, 0, 0, 0, 66, 65);
      chk("t5_valid_c66", 32'(p_val[0]), 32'd1);
      chk("t5_error_c66", 32'(p_err[0]), 32'd0);
      chk("t5_result_c66", p_res[0], 32'h0BAD_F00D);

      // done during ISSUE is ignored; the later one is taken
      run_op(0, 32'h7, 32'h8, 32'h1111_1111, 3, 0, 1, 0, 0, 2, 4);
      chk("t6_valid_c2", 32'(p_val[0]), 32'd0);
      chk("t6_valid_c4", 32'(p_val[1]), 32'd1);

      // reset pulse during WAIT
      run_op(3, 32'h9, 32'hA, 32'h0, 0, 0, 0, 0, 10, 10, 9);
      chk("t7_busy_rst",   32'(p_busy[0]), 32'd0);
      chk("t7_select_rst", 32'(p_sel[0]), 32'd0);
      chk("t7_result_rst", p_res[0], 32'd0);
      chk("t7_busy_c9",    32'(p_busy[1]), 32'd1);

      // accepted normally after the reset, then back-to-back
      run_op(3, 32'hDEAD_0000, 32'hBEEF_0000, 32'h7654_3210, 2, 0, 0, 0, 0, 1, 3);
      chk("t8_unit_start_c1", 32'(p_us[0]), 32'h0000_0008);
      chk("t8_result_c3",     p_res[1], 32'h7654_3210);
      run_op(0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hCAFE_BABE, 5, 0, 0, 0, 0, 6, 1);
      chk("t9_result_c6", p_res[0], 32'hCAFE_BABE);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fpu_op_dispatch.md
# fpu_op_dispatch

Sequencing controller for the co-processor's operand-routing demux and its bank of floating-point functional units. Accepts one operation request (opcode plus two 32-bit operands), holds the operands and the unit select stable, and pulses a start to the selected unit. It then waits for that unit's done, captures its result and presents it with a one-cycle valid. The block sits between the host-interface decode logic and the demux/functional-unit array, and guarantees at most one operation in flight.

## Interface
- NUM_UNITS, 6: number of functional units behind the demux; legal range 1..8.
- TIMEOUT, 64: maximum WAIT cycles before an operation is aborted; minimum 2.

- clk  in  1  system clock, rising-edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- opcode  in  3  target unit index.
- op1  in  32  operand 1.
- op2  in  32  operand 2.
- unit_done  in  NUM_UNITS  per-unit completion strobe.
- unit_result  in  NUM_UNITS*32  per-unit result, packed; unit i occupies bits [32*i+31:32*i].
- select  out  3  registered demux select.
- op1_q  out  32  registered operand 1 driven to the demux.
- op2_q  out  32  registered operand 2 driven to the demux.
- unit_start  out  NUM_UNITS  one-hot start pulse to the selected unit.
- result  out  32  captured result; holds its value until the next capture.
- result_valid  out  1  one-cycle pulse: result is new.
- busy  out  1  high whenever state is not IDLE.
- error  out  1  one-cycle pulse: illegal opcode or timeout.

## Operation
- Reset (n_rst low, asynchronous): state IDLE; select, op1_q, op2_q, result, the timeout counter and error are cleared to 0. unit_start, result_valid and busy are low.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, start=1, opcode < NUM_UNITS: latch opcode into select, op1 into op1_q and op2 into op2_q. Next state is ISSUE.
- IDLE, start=1, opcode >= NUM_UNITS: error pulses high in the next cycle. State stays IDLE, and select and the operands are not updated.
- ISSUE: unit_start[select] = 1; all other unit_start bits are 0. The timeout counter clears. Next state is WAIT.
- WAIT, unit_done[select] = 1: result takes unit_result slice [select]. Next state is DONE.
- WAIT, no done: the counter increments. When the counter equals TIMEOUT-1 with no done, error pulses in the next cycle and the next state is IDLE. result is unchanged.
- If done and the timeout condition occur in the same cycle, done wins: result is captured and there is no error.
- DONE: result_valid = 1. Next state is IDLE.
- unit_done bits of non-selected units are ignored in every state. unit_done is also ignored outside WAIT.
- start is ignored while busy. There is no queuing; the requester must wait for busy low.
- select, op1_q and op2_q stay constant from ISSUE through DONE. They retain their values in IDLE until the next accepted start.
- Counter width is clog2(TIMEOUT); it saturates and never wraps within WAIT.

## Timing
- unit_start, result_valid and busy are decoded from registered state. error is a registered pulse.
- Start sampled at edge 0: select and the operands are valid and unit_start is high during cycle 1.
- Earliest unit_done is sampled in cycle 2 (first WAIT cycle), which puts result_valid and the new result in cycle 3. Minimum start-to-valid latency is 3 cycles.
- In general, result_valid asserts exactly 1 cycle after the cycle in which unit_done[select] is sampled high.
- The timeout error asserts TIMEOUT+2 cycles after the start edge; busy drops in the same cycle.
- A new start may be sampled in the cycle after DONE (busy low), giving a back-to-back throughput of one operation per 4 cycles minimum.
- Reset asserted mid-operation aborts immediately: all outputs return to their reset values, and no result_valid or error is produced.

## Test plan
- Reset, then start with opcode=2, op1=0x3F800000, op2=0x40000000. Unit 2 raises done 1 cycle after its start with result 0x40400000. Expect unit_start=0b000100 in cycle 1 only, and result=0x40400000 with result_valid in cycle 3.
- Opcode=7 with NUM_UNITS=6: expect one error pulse, busy stays 0, and select keeps its prior value.
- Opcode=1 with unit_done[1] never asserted and TIMEOUT=64: expect error at cycle 66, busy low in the same cycle, and result unchanged.
- Opcode=4 with unit_done[3] strobed during WAIT and unit_done[4] 5 cycles later: only unit 4's result is captured, and start pulses issued during the busy cycles are ignored.
- unit_done[select] arriving exactly on the TIMEOUT-1 count: expect result_valid, no error.
- n_rst pulsed low during WAIT: all outputs return to reset values immediately, and the next start is accepted normally.
